// File: rtl/sram_bus_ctrl.sv
// Single-beat request/ack master for a 64Kx8 asynchronous SRAM: SETUP / ACCESS / HOLD / DONE strobing.
// Optional macro SRAM_BUS_BACK2BACK_EN: a request seen in DONE is accepted directly into SETUP.
module sram_bus_ctrl #(
   parameter int unsigned WAIT_STATES   = 2,
   parameter logic [7:0]  DRIVE_DEFAULT = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        ack,
   output logic        busy,
   output logic [15:0] ram_addr,
   inout  wire  [7:0]  ram_data,
   output logic        ram_cs_n,
   output logic        ram_we_n,
   output logic        ram_oe_n
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        lat_we;
   logic [7:0]  lat_wdata;
   logic        drive;
   logic        accept;

`ifdef SRAM_BUS_BACK2BACK_EN
   assign accept = req && (state == IDLE || state == DONE);
`else
   assign accept = req && (state == IDLE);
`endif

   // Data bus is driven only from SETUP through HOLD of a write.
   assign ram_data = drive ? lat_wdata : 8'hzz;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_we    <= 1'b0;
         lat_wdata <= DRIVE_DEFAULT;
         drive     <= 1'b0;
         ram_addr  <= 16'h0000;
         ram_cs_n  <= 1'b1;
         ram_we_n  <= 1'b1;
         ram_oe_n  <= 1'b1;
         rdata     <= 8'h00;
         ack       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         ack <= 1'b0;
         if (accept) begin
            state     <= SETUP;
            lat_we    <= we;
            lat_wdata <= wdata;
            ram_addr  <= addr;
            cnt       <= WAIT_INIT;
            drive     <= we;
            ram_cs_n  <= 1'b0;
            ram_we_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            busy      <= 1'b1;
         end else begin
            case (state)
               SETUP: begin
                  state <= ACCESS;
                  if (lat_we) ram_we_n <= 1'b0;
                  else        ram_oe_n <= 1'b0;
               end
               ACCESS: begin
                  // Read data is captured while OE is still low, on the edge that ends the access.
                  if (cnt == 4'd0) begin
                     state    <= HOLD;
                     ram_we_n <= 1'b1;
                     ram_oe_n <= 1'b1;
                     if (!lat_we) rdata <= ram_data;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
               HOLD: begin
                  state    <= DONE;
                  ram_cs_n <= 1'b1;
                  drive    <= 1'b0;
                  ack      <= 1'b1;
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Scoreboard bench for sram_bus_ctrl: timing model of accepts, SRAM behavioural model, expected-result queue.
// A second instance with WAIT_STATES=0 covers the short-latency read.
module tb_sram_bus_ctrl;

   localparam int WS = 2;
`ifdef SRAM_BUS_BACK2BACK_EN
   localparam int SPACING = WS + 4;
`else
   localparam int SPACING = WS + 5;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  wdata = 8'h00;
   logic [7:0]  rdata;
   logic        ack, busy;
   logic [15:0] ram_addr;
   wire  [7:0]  ram_data;
   logic        cs_n, we_n, oe_n;

   logic        req0 = 1'b0;
   logic [7:0]  rdata0;
   logic        ack0, busy0;
   logic [15:0] ram_addr0;
   wire  [7:0]  ram_data0;
   logic        cs0_n, we0_n, oe0_n;

   always #5 clk = ~clk;

   sram_bus_ctrl #(.WAIT_STATES(WS), .DRIVE_DEFAULT(8'h00)) u_dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data),
      .ram_cs_n(cs_n), .ram_we_n(we_n), .ram_oe_n(oe_n)
   );

   sram_bus_ctrl #(.WAIT_STATES(0), .DRIVE_DEFAULT(8'h00)) u_dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(1'b0), .addr(16'hFFFF), .wdata(8'h00),
      .rdata(rdata0), .ack(ack0), .busy(busy0), .ram_addr(ram_addr0), .ram_data(ram_data0),
      .ram_cs_n(cs0_n), .ram_we_n(we0_n), .ram_oe_n(oe0_n)
   );

   // SRAM model: uninitialised cells read 8'h76, writes land on the rising edge of WE.
   // A released bus floats high through the pull-ups, so it reads 8'hFF.
   logic [7:0] mem [0:65535] = '{default: 8'h76};
   assign ram_data  = (!cs_n && !oe_n && we_n) ? mem[ram_addr] : 8'hzz;
   assign ram_data0 = (!cs0_n && !oe0_n && we0_n) ? 8'h76 : 8'hzz;
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (ram_data[g]);
   end
   always @(posedge we_n) if (!cs_n) mem[ram_addr] <= ram_data;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        wr;
      logic [15:0] a;
      logic [7:0]  d;
      int          ack_at;
   } txn_t;

   txn_t        sb[$];
   logic [7:0]  shadow [0:65535] = '{default: 8'h76};
   int          cyc = 0;
   int          next_ok = 0;
   int          idx = 0;
   logic [15:0] last_addr = 16'h0000;

   // Reference timing: an accept is possible every SPACING edges; ack lands WS+4 edges later.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sb.delete();
         cyc     <= 0;
         next_ok <= 0;
      end else begin
         cyc <= cyc + 1;
         if (req && cyc >= next_ok) begin
            sb.push_back('{wr: we, a: addr, d: (we ? wdata : shadow[addr]), ack_at: cyc + WS + 4});
            if (we) shadow[addr] <= wdata;
            next_ok   <= cyc + SPACING;
            idx       <= idx + 1;
            last_addr <= addr;
         end
      end
   end

   int         we_lo = 0;
   int         oe_lo = 0;
   logic [7:0] last_rd = 8'h00;

   always @(negedge clk) begin
      if (reset) begin
         we_lo   <= 0;
         oe_lo   <= 0;
         last_rd <= 8'h00;
      end else begin
         chk("busy", 32'(busy), 32'(sb.size() != 0));
         chk("we_oe_overlap", 32'(!we_n && !oe_n), 0);
         chk("bus_release", 32'(cs_n && (ram_data != 8'hFF)), 0);
         if (!cs_n && sb.size() != 0) chk("ram_addr", 32'(ram_addr), 32'(sb[0].a));
         if (!we_n && sb.size() != 0) chk("ram_wdata", 32'(ram_data), 32'(sb[0].d));
         if (!we_n) we_lo <= we_lo + 1;
         else if (we_lo != 0) begin
            chk("we_pulse", we_lo, WS + 1);
            we_lo <= 0;
         end
         if (!oe_n) oe_lo <= oe_lo + 1;
         else if (oe_lo != 0) begin
            chk("oe_pulse", oe_lo, WS + 1);
            oe_lo <= 0;
         end
         if (ack) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", 32'(ack), 0);
            end else begin
               chk("ack_cycle", cyc, sb[0].ack_at);
               if (sb[0].wr) begin
                  chk("sram_write", 32'(mem[sb[0].a]), 32'(sb[0].d));
                  chk("rdata_hold", 32'(rdata), 32'(last_rd));
               end else begin
                  chk("rdata", 32'(rdata), 32'(sb[0].d));
                  last_rd <= sb[0].d;
               end
               void'(sb.pop_front());
            end
         end else if (sb.size() != 0 && cyc > sb[0].ack_at) begin
            chk("ack_missing", 32'(ack), 1);
            void'(sb.pop_front());
         end
      end
   end

   logic        s_we [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [15:0] s_a  [5] = '{16'h0010, 16'h0010, 16'h0020, 16'h0020, 16'h0010};
   logic [7:0]  s_d  [5] = '{8'h3C, 8'h00, 8'h5A, 8'h00, 8'h00};

   task automatic do_txn(input logic w, input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      chk("drain", 32'(sb.size()), 0);
   endtask

   // req stays high; inputs are scrambled whenever the controller should be ignoring them.
   task automatic stream();
      int base, guard, k;
      base = idx;
      guard = 0;
      while (idx - base < 5 && guard < 300) begin
         @(negedge clk);
         guard++;
         req = 1'b1;
         k = idx - base;
         if (cyc >= next_ok && k < 5) begin
            we = s_we[k]; addr = s_a[k]; wdata = s_d[k];
         end else begin
            we = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
         end
      end
      req = 1'b0;
      chk("stream_count", idx - base, 5);
      wait_drain();
   endtask

   task automatic ws0_read();
      int n;
      @(negedge clk);
      req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      n = 1;
      while (!ack0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ws0_latency", n, 4);
      chk("ws0_rdata", 32'(rdata0), 32'h76);
      @(negedge clk);
      chk("ws0_busy_after", 32'(busy0), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_cs_n", 32'(cs_n), 1);
      chk("rst_we_n", 32'(we_n), 1);
      chk("rst_oe_n", 32'(oe_n), 1);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_data_released", 32'(ram_data), 32'hFF);
      reset = 1'b0;

      do_txn(1'b1, 16'h1234, 8'hA5);
      wait_drain();
      do_txn(1'b0, 16'h1234, 8'h00);
      wait_drain();
      do_txn(1'b0, 16'hFFFF, 8'h00);
      wait_drain();
      ws0_read();

      stream();
      chk("addr_hold_idle", 32'(ram_addr), 32'(last_addr));

      do_txn(1'b1, 16'h0BAD, 8'h77);
      for (int i = 0; i < 8 && we_n; i++) @(negedge clk);
      chk("abort_in_access", 32'(we_n), 0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_we_n", 32'(we_n), 1);
      chk("abort_cs_n", 32'(cs_n), 1);
      chk("abort_oe_n", 32'(oe_n), 1);
      chk("abort_data_released", 32'(ram_data), 32'hFF);
      chk("abort_ack", 32'(ack), 0);
      chk("abort_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("rdata_after_reset", 32'(rdata), 0);

      do_txn(1'b0, 16'h1234, 8'h00);
      wait_drain();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_bus_ctrl.md
Name: sram_bus_ctrl

Overview:
Synchronous bus master that turns a single-beat CPU-side request/acknowledge transaction into correctly sequenced strobes for the 64Kx8 asynchronous SRAM. It sits directly upstream of the SRAM and drives its address, bidirectional data and active-low CS/WE/OE. It guarantees setup, hold and no-overlap timing on the SRAM side and returns read data with a one-cycle ack pulse.

Parameters:
WAIT_STATES, 2, extra ACCESS cycles beyond the first; legal range 0..15
DRIVE_DEFAULT, 8'h00, value of ram_data_o-side holding register after reset

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  request strobe; sampled only in IDLE
we  input  1  1 = write, 0 = read; latched with req
addr  input  16  transaction address; latched with req
wdata  input  8  write data; latched with req
rdata  output  8  read data; valid from ack cycle until next read completes
ack  output  1  one-cycle completion pulse
busy  output  1  high from the cycle after acceptance through the ack cycle
ram_addr  output  16  SRAM address
ram_data  inout  8  SRAM data bus; driven only during write SETUP/ACCESS/HOLD, else 'z
ram_cs_n  output  1  SRAM chip select, active low
ram_we_n  output  1  SRAM write enable, active low
ram_oe_n  output  1  SRAM output enable, active low

Behaviour:
- Reset (async, immediate): state IDLE; ram_cs_n=ram_we_n=ram_oe_n=1; ram_data released to 'z; ram_addr=0; rdata=0; ack=0; busy=0; wait counter=0; latched write data=DRIVE_DEFAULT.
- All SRAM-side outputs and ack/busy/rdata are registered; no combinational path from req to any strobe.
- States: IDLE, SETUP, ACCESS, HOLD, DONE.
- IDLE: req=1 at edge -> latch we/addr/wdata, load counter=WAIT_STATES, go SETUP. req=0 -> stay.
- SETUP (1 cycle): ram_addr=latched addr, ram_cs_n=0, WE/OE high; write: ram_data driven with latched wdata.
- ACCESS (WAIT_STATES+1 cycles): read: ram_oe_n=0; write: ram_we_n=0, data still driven. Counter decrements each cycle; leave when counter=0. Read data sampled from ram_data into rdata on the edge leaving ACCESS.
- HOLD (1 cycle): WE/OE high, ram_cs_n=0, address and write data held.
- DONE (1 cycle): ram_cs_n=1, bus released, ack=1, busy=1; next state IDLE.
- Latency: ack asserted WAIT_STATES+4 cycles after the accepting edge (WAIT_STATES=2 -> 6). Minimum spacing between accepted requests WAIT_STATES+5 cycles.
- Invariant: ram_we_n and ram_oe_n never both 0 in any cycle; ram_we_n never 0 while ram_data undriven.
- req held high or re-pulsed while busy: ignored, not queued; addr/we/wdata changes while busy have no effect.
- ram_addr keeps last value in IDLE; rdata unchanged by writes.
- Reset mid-transaction: strobes deassert asynchronously; no ack for the aborted transaction; partial write contents in SRAM undefined.

Optional Feature:
SRAM_BUS_BACK2BACK_EN: when defined, DONE with req=1 latches the new request and goes directly to SETUP (ack still pulses in DONE), so spacing drops to WAIT_STATES+4 cycles; strobes still all high in DONE, preserving no-overlap. When undefined, DONE always returns to IDLE and req in DONE is ignored.

Test Plan:
- Reset asserted mid-ACCESS of a write (WAIT_STATES=2) -> same-cycle ram_we_n=1, ram_cs_n=1, ram_data='z, no ack.
- Write addr=16'h1234 wdata=8'hA5 -> SETUP/3xACCESS/HOLD sequence, ram_we_n low exactly 3 cycles, ack 6 cycles after accept, SRAM[1234]=A5.
- Read addr=16'h1234 after prior write -> ram_oe_n low 3 cycles, rdata=8'hA5 with ack, busy low the cycle after.
- Read uninitialized addr=16'hFFFF -> rdata=8'h76; WAIT_STATES=0 variant -> ack 4 cycles after accept.
- req held high continuously, alternating write 8'h3C@0010 / read @0010 -> every transaction spaced 7 cycles (5+WAIT_STATES), read returns 8'h3C, WE/OE never both low (assertion).
- With SRAM_BUS_BACK2BACK_EN, req held high -> DONE followed immediately by SETUP, spacing 6 cycles, data correct.
